seq_pattern_detect: RTL and testbench
=====================================

# seq_pattern_detect

Parametrised serial pattern detector, the successor to the fixed two-bit `11` pair detector. It samples one bit per enabled clock and compares it against a compile-time pattern of configurable width. It runs in overlapping or non-overlapping mode and keeps a saturating count of matches. It sits on the serial-input path of the FSM lab designs and replaces per-pattern hand-coded FSMs.

## Interface
- `PAT_W`, 2: pattern length in bits, legal range 1..32.
- `PATTERN`, `2'b11`: pattern value; `PATTERN[PAT_W-1]` is the first bit received.
- `OVERLAP`, 1: 1 = overlapping detection; 0 = non-overlapping detection.
- `CNT_W`, 8: match-counter width, legal range 1..32.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: bit-valid qualifier; `inbits` is sampled only when `en`=1.
- `inbits`  in  1: serial data bit.
- `clr_cnt`  in  1: synchronous clear of `match_cnt` and `cnt_sat`.
- `detect`  out  1: registered one-cycle match pulse.
- `match_cnt`  out  CNT_W: number of matches since reset or clear; saturating.
- `cnt_sat`  out  1: high while `match_cnt` is all ones.

## Operation
- Internal state:
  - history shift register `hist[PAT_W-1:0]`, newest bit in the LSB;
  - fill counter `fill`, range 0..PAT_W, saturating at PAT_W.
- On an edge with `en`=1:
  - `next_hist = {hist[PAT_W-2:0], inbits}`; for PAT_W=1 this is just `inbits`;
  - `next_fill = min(fill+1, PAT_W)`;
  - `hit = (next_fill == PAT_W) && (next_hist == PATTERN)`.
- On a hit:
  - `detect` is 1 in the next cycle;
  - `match_cnt` increments unless it is saturated;
  - with `OVERLAP`=1, `hist` keeps `next_hist` and `fill` stays PAT_W, so the suffix bits of the match can start the next match;
  - with `OVERLAP`=0, `fill` is cleared to 0 and the next match needs PAT_W fresh bits.
- With `en`=0: `hist`, `fill` and `match_cnt` hold; `detect` is 0.
- Counter behaviour:
  - saturates at 2^CNT_W−1 and never wraps;
  - `cnt_sat` = (`match_cnt` == all ones), decoded combinationally from the register.
- `clr_cnt` and a hit in the same cycle: the clear wins, so `match_cnt` becomes 0. `detect` still pulses.
- `clr_cnt` has no effect on `hist`, `fill` or `detect`.
- Detector state machine, expressed as `fill`:
  - FILL states (`fill` < PAT_W): no hit is possible;
  - ARMED state (`fill` == PAT_W): every enabled bit is compared against the pattern.

## Timing
- Reset values (asynchronous, immediately on `reset`=0): `hist`=0, `fill`=0, `detect`=0, `match_cnt`=0, `cnt_sat`=0.
- Reset mid-pattern discards all partial history. The first hit after reset needs PAT_W enabled bits.
- Deassertion of reset is synchronised externally; the block adds no reset synchroniser.
- Latency: `detect` rises on the edge that samples the last pattern bit. It is high for exactly one clock cycle, in the cycle after that bit was presented.
- `match_cnt` updates on the same edge that sets `detect`, so both are visible together.
- Back-to-back hits (OVERLAP=1 with a self-overlapping pattern) give `detect` high on consecutive cycles, one pulse per hit.
- Gaps in `en` are transparent: bits are contiguous in the enabled-bit stream, not in clock cycles.

## Structure
- Package `seq_detect_pkg` holds:
  - default constants `SEQ_PAT_W_DEF`, `SEQ_PATTERN_DEF`, `SEQ_CNT_W_DEF`;
  - an elaboration-time check function `seq_params_ok(PAT_W, CNT_W)`.
- The top level asserts `seq_params_ok` at elaboration.
- One sub-module, `sat_counter`:
  - parameter `W`;
  - ports: `clk`, `reset`, `inc`, `clr`, `q`, `sat`;
  - clear has priority over increment.
- The shift register, fill logic and detect flop live in the top module.

## Test plan
- Default parameters (PAT_W=2, PATTERN=`11`, OVERLAP=1), input 1,0,1,0,1,1,1,0 with `en`=1 → `detect` pulses after the 6th and 7th bits; `match_cnt`=2.
- Same input with OVERLAP=0 → a single pulse after the 6th bit; `match_cnt`=1.
- PAT_W=4, PATTERN=`1011`, OVERLAP=1, input 1,0,1,1,0,1,1 → pulses after bits 4 and 7; `match_cnt`=2.
- Toggle `en` low for 3 cycles between the two `1` bits of `11` → exactly one pulse, one cycle after the second enabled `1`.
- Assert `reset`=0 after the first `1` of `11`, release it, then send a single `1` → no pulse. A following `1` → pulse.
- CNT_W=2, five hits → `match_cnt` stops at 3 and `cnt_sat`=1. Then `clr_cnt` in the same cycle as a hit → `match_cnt`=0, `cnt_sat`=0, `detect` still pulses.

Source files
------------

// File: rtl/seq_pattern_detect_pkg.sv
// Shared defaults and parameter legality check
// for the serial pattern detector.
package seq_detect_pkg;

    localparam int          SEQ_PAT_W_DEF   = 2;
    localparam logic [31:0] SEQ_PATTERN_DEF = 32'b11;
    localparam int          SEQ_CNT_W_DEF   = 8;

    function automatic bit seq_params_ok(input int pat_w, input int cnt_w);
        return (pat_w >= 1) && (pat_w <= 32) &&
               (cnt_w >= 1) && (cnt_w <= 32);
    endfunction

endpackage

// File: rtl/seq_pattern_detect_sat_counter.sv
// Saturating up-counter with synchronous clear;
// clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !(&q_q)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign sat = &q_q;

endmodule

// File: rtl/seq_pattern_detect.sv
// Parametrised serial pattern detector with
// overlap control and saturating match count.
module seq_pattern_detect
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = SEQ_PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN_DEF[PAT_W-1:0],
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = SEQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inbits,
    input  logic             clr_cnt,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (!seq_params_ok(PAT_W, CNT_W)) begin : g_bad_params
        $error("seq_pattern_detect: PAT_W/CNT_W out of range");
    end

    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [PAT_W-1:0] shift_hist;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic [FW-1:0]    bump_fill;
    logic             detect_q;
    logic             detect_d;
    logic             hit;

    if (PAT_W == 1) begin : g_w1
        assign shift_hist = inbits;
    end else begin : g_wn
        assign shift_hist = {hist_q[PAT_W-2:0], inbits};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q   <= '0;
            fill_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            detect_q <= detect_d;
        end
    end

    // fill < FULL is a FILL state; fill == FULL is ARMED
    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        detect_d = hit;
        if (en) begin
            hist_d = shift_hist;
            if (hit && (OVERLAP == 1'b0)) begin
                fill_d = '0;
            end else begin
                fill_d = bump_fill;
            end
        end
    end

    always_comb begin
        bump_fill = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit = en && (bump_fill == FULL) && (shift_hist == PATTERN);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clr_cnt),
        .q     (match_cnt),
        .sat   (cnt_sat)
    );

    assign detect = detect_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Self-checking bench: four detector configs
// on a shared stream against a behavioural model.
module tb_seq_pattern_detect;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic inbits = 1'b0;
    logic clr_cnt = 1'b0;

    logic       det0, det1, det2, det3;
    logic       sat0, sat1, sat2, sat3;
    logic [7:0] mc0, mc1, mc2;
    logic [1:0] mc3;

    always #5 clk = ~clk;

    seq_pattern_detect #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .reset(rst_n), .en(en), .inbits(inbits), .clr_cnt(clr_cnt),
        .detect(det0), .match_cnt(mc0), .cnt_sat(sat0));
    seq_pattern_detect #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .reset(rst_n), .en(en), .inbits(inbits), .clr_cnt(clr_cnt),
        .detect(det1), .match_cnt(mc1), .cnt_sat(sat1));
    seq_pattern_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .clk(clk), .reset(rst_n), .en(en), .inbits(inbits), .clr_cnt(clr_cnt),
        .detect(det2), .match_cnt(mc2), .cnt_sat(sat2));
    seq_pattern_detect #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u3 (
        .clk(clk), .reset(rst_n), .en(en), .inbits(inbits), .clr_cnt(clr_cnt),
        .detect(det3), .match_cnt(mc3), .cnt_sat(sat3));

    logic det [4];
    logic sat [4];
    int   cnt [4];
    assign det[0] = det0;
    assign det[1] = det1;
    assign det[2] = det2;
    assign det[3] = det3;
    assign sat[0] = sat0;
    assign sat[1] = sat1;
    assign sat[2] = sat2;
    assign sat[3] = sat3;
    assign cnt[0] = int'(mc0);
    assign cnt[1] = int'(mc1);
    assign cnt[2] = int'(mc2);
    assign cnt[3] = int'(mc3);

    int cfg_pw  [4] = '{2, 2, 4, 2};
    int cfg_pat [4] = '{3, 3, 11, 3};
    bit cfg_ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cfg_max [4] = '{255, 255, 255, 3};

    // model: count of fresh bits and value of the last pw bits
    int m_seen [4];
    int m_hv   [4];
    int m_cnt  [4];
    bit m_det  [4];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_seen[k] = 0;
            m_hv[k]   = 0;
            m_cnt[k]  = 0;
            m_det[k]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit e, input bit b, input bit c);
        en      = e;
        inbits  = b;
        clr_cnt = c;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            m_det[k] = 1'b0;
            if (e) begin
                m_seen[k] = m_seen[k] + 1;
                m_hv[k] = (m_hv[k] * 2 + int'(b)) % (1 << cfg_pw[k]);
                if (m_seen[k] >= cfg_pw[k] && m_hv[k] == cfg_pat[k]) begin
                    m_det[k] = 1'b1;
                    if (!cfg_ov[k]) m_seen[k] = 0;
                end
            end
            if (c) m_cnt[k] = 0;
            else if (m_det[k] && m_cnt[k] < cfg_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        inbits = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (det[k] !== 1'b0 || cnt[k] != 0 || sat[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: det=%b cnt=%0d sat=%b, want 0/0/0",
                         k, det[k], cnt[k], sat[k]);
            end
        end
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit seq [8] = '{1, 0, 1, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[i], 1'b0);
            checks++;
            if (det0 !== (i == 5 || i == 6)) begin
                errors++;
                $display("FAIL basic_ovl bit%0d: detect=%b want %b", i + 1, det0, (i == 5 || i == 6));
            end
            checks++;
            if (det1 !== (i == 5)) begin
                errors++;
                $display("FAIL basic_novl bit%0d: detect=%b want %b", i + 1, det1, (i == 5));
            end
        end
        checks++;
        if (cnt[0] != 2) begin
            errors++;
            $display("FAIL basic_ovl_cnt: got %0d want 2", cnt[0]);
        end
        checks++;
        if (cnt[1] != 1) begin
            errors++;
            $display("FAIL basic_novl_cnt: got %0d want 1", cnt[1]);
        end
    endtask

    task automatic test_pat4();
        bit seq [7] = '{1, 0, 1, 1, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq[i], 1'b0);
            checks++;
            if (det2 !== (i == 3 || i == 6)) begin
                errors++;
                $display("FAIL pat4 bit%0d: detect=%b want %b", i + 1, det2, (i == 3 || i == 6));
            end
        end
        checks++;
        if (cnt[2] != 2) begin
            errors++;
            $display("FAIL pat4_cnt: got %0d want 2", cnt[2]);
        end
    endtask

    task automatic test_en_gap();
        int pulses = 0;
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        if (det0) pulses++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'(i), 1'b0);
            if (det0) pulses++;
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (det0 !== 1'b1) begin
            errors++;
            $display("FAIL en_gap_pulse: detect=%b want 1", det0);
        end
        if (det0) pulses++;
        step(1'b0, 1'b1, 1'b0);
        if (det0) pulses++;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL en_gap_count: pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (det0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_first: detect=%b want 0", det0);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (det0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_second: detect=%b want 1", det0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt[3] != 3 || sat3 !== 1'b1) begin
            errors++;
            $display("FAIL sat_stop: cnt=%0d sat=%b want 3/1", cnt[3], sat3);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (det3 !== 1'b1 || cnt[3] != 0 || sat3 !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr_hit: det=%b cnt=%0d sat=%b want 1/0/0", det3, cnt[3], sat3);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 39) == 0));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (det[k] !== m_det[k] || cnt[k] != m_cnt[k] ||
                    sat[k] !== (m_cnt[k] == cfg_max[k])) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d: det=%b cnt=%0d sat=%b want %b/%0d/%b",
                             i, k, det[k], cnt[k], sat[k], m_det[k], m_cnt[k],
                             (m_cnt[k] == cfg_max[k]));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_pat4();
        test_en_gap();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
